// File: rtl/retire_trace_buffer_if.sv
// Retire-port and trace-drain signal bundle for retire_trace_buffer.
// The core/drain side uses master; the monitor uses slave.
interface retire_trace_buffer_if #(
    parameter int PC_W   = 16,
    parameter int DATA_W = 16,
    parameter int REG_W  = 4,
    parameter int CNT_W  = 32
);
    logic              ret_valid;
    logic [PC_W-1:0]   ret_pc;
    logic              ret_regwrite;
    logic [REG_W-1:0]  ret_wreg;
    logic [DATA_W-1:0] ret_wdata;
    logic              ret_memread;
    logic              ret_memwrite;
    logic [DATA_W-1:0] ret_memaddr;
    logic [DATA_W-1:0] ret_memdata;
    logic              ret_halt;

    logic              tr_valid;
    logic              tr_ready;
    logic [2:0]        tr_type;
    logic [CNT_W-1:0]  tr_inum;
    logic [PC_W-1:0]   tr_pc;
    logic [DATA_W-1:0] tr_a;
    logic [DATA_W-1:0] tr_b;
    logic [DATA_W-1:0] tr_c;

    modport master (
        output ret_valid, ret_pc, ret_regwrite, ret_wreg, ret_wdata,
               ret_memread, ret_memwrite, ret_memaddr, ret_memdata, ret_halt,
               tr_ready,
        input  tr_valid, tr_type, tr_inum, tr_pc, tr_a, tr_b, tr_c
    );

    modport slave (
        input  ret_valid, ret_pc, ret_regwrite, ret_wreg, ret_wdata,
               ret_memread, ret_memwrite, ret_memaddr, ret_memdata, ret_halt,
               tr_ready,
        output tr_valid, tr_type, tr_inum, tr_pc, tr_a, tr_b, tr_c
    );
endinterface

// File: rtl/retire_trace_buffer.sv
// Retire-event monitor: classifies retired instructions, buffers trace records in a FIFO,
// keeps cycle/instruction/drop counters, halt latch and watchdog. Optional: TRACE_FILTER_EN.
module retire_trace_buffer #(
    parameter int PC_W       = 16,
    parameter int DATA_W     = 16,
    parameter int REG_W      = 4,
    parameter int DEPTH      = 8,
    parameter int CNT_W      = 32,
    parameter int MAX_CYCLES = 100000
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef TRACE_FILTER_EN
    input  logic               filter_nop,
`endif
    retire_trace_buffer_if.slave bus,
    output logic [CNT_W-1:0]   cycle_count,
    output logic [CNT_W-1:0]   inst_count,
    output logic [CNT_W-1:0]   drop_count,
    output logic               overflow,
    output logic               halted,
    output logic               timeout
);
    localparam int AW    = $clog2(DEPTH);
    localparam int REC_W = 3 + CNT_W + PC_W + 3 * DATA_W;

    localparam logic [AW:0]      PTR_ONE  = (AW + 1)'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(MAX_CYCLES);

    typedef enum logic [2:0] {
        T_NOP   = 3'd0,
        T_REG   = 3'd1,
        T_LOAD  = 3'd2,
        T_STORE = 3'd3,
        T_HALT  = 3'd4
    } rec_type_t;

    rec_type_t         rtype_s;
    logic [DATA_W-1:0] a_s;
    logic [DATA_W-1:0] b_s;
    logic [DATA_W-1:0] c_s;
    logic [REC_W-1:0]  rec_s;
    logic [REC_W-1:0]  head_rec_s;

    logic [REC_W-1:0]  mem_r [DEPTH];
    logic [AW:0]       wr_ptr_r;
    logic [AW:0]       rd_ptr_r;

    logic run_s, cap_s, push_req_s, push_s, pop_s, drop_s, empty_s, full_s;

    // Classify the retiring instruction and select its payload fields
    always_comb begin
        rtype_s = T_NOP;
        a_s     = {DATA_W{1'b0}};
        b_s     = {DATA_W{1'b0}};
        c_s     = {DATA_W{1'b0}};
        if (bus.ret_regwrite && bus.ret_memread) begin
            rtype_s = T_LOAD;
            a_s     = DATA_W'(bus.ret_wreg);
            b_s     = bus.ret_wdata;
            c_s     = bus.ret_memaddr;
        end else if (bus.ret_regwrite) begin
            rtype_s = T_REG;
            a_s     = DATA_W'(bus.ret_wreg);
            b_s     = bus.ret_wdata;
        end else if (bus.ret_halt) begin
            rtype_s = T_HALT;
        end else if (bus.ret_memwrite) begin
            rtype_s = T_STORE;
            a_s     = bus.ret_memaddr;
            b_s     = bus.ret_memdata;
        end else begin
            rtype_s = T_NOP;
        end
    end

    assign rec_s   = {rtype_s, inst_count, bus.ret_pc, a_s, b_s, c_s};
    assign run_s   = ~halted & ~timeout;
    assign cap_s   = bus.ret_valid & run_s;

`ifdef TRACE_FILTER_EN
    assign push_req_s = cap_s & ~(filter_nop & (rtype_s == T_NOP));
`else
    assign push_req_s = cap_s;
`endif

    // Extra pointer MSB distinguishes full from empty when the indices match
    assign empty_s = (wr_ptr_r == rd_ptr_r);
    assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign pop_s   = ~empty_s & bus.tr_ready;
    assign push_s  = push_req_s & (~full_s | pop_s);
    assign drop_s  = push_req_s & full_s & ~pop_s;

    // Head record presented to the drain; zeroed while the FIFO is empty
    always_comb begin
        head_rec_s = {REC_W{1'b0}};
        if (empty_s) begin
            head_rec_s = {REC_W{1'b0}};
        end else begin
            head_rec_s = mem_r[rd_ptr_r[AW-1:0]];
        end
    end

    assign bus.tr_valid = ~empty_s;
    assign {bus.tr_type, bus.tr_inum, bus.tr_pc, bus.tr_a, bus.tr_b, bus.tr_c} = head_rec_s;

    // Record storage
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= rec_s;
        end
    end

    // FIFO pointers, counters and sticky status
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r    <= {(AW + 1){1'b0}};
            rd_ptr_r    <= {(AW + 1){1'b0}};
            cycle_count <= {CNT_W{1'b0}};
            inst_count  <= {CNT_W{1'b0}};
            drop_count  <= {CNT_W{1'b0}};
            overflow    <= 1'b0;
            halted      <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            if (run_s && (cycle_count != CNT_MAX)) begin
                cycle_count <= cycle_count + CNT_ONE;
            end
            if (run_s && (cycle_count >= WD_LIMIT)) begin
                timeout <= 1'b1;
            end
            if (cap_s) begin
                inst_count <= inst_count + CNT_ONE;
            end
            // A HALT latches even when its record is dropped
            if (cap_s && (rtype_s == T_HALT)) begin
                halted <= 1'b1;
            end
            if (drop_s) begin
                overflow <= 1'b1;
                if (drop_count != CNT_MAX) begin
                    drop_count <= drop_count + CNT_ONE;
                end
            end
        end
    end
endmodule
